// File: rtl/ps2_pkg.sv
// ps2_pkg - shared definitions for the PS/2 keyboard front end.
//   * Scan-code set 2 constants for the keys the menu and game logic watch,
//     plus the two prefix bytes (extended, break).
//   * Receiver state encoding used by ps2_rx_frame.
//   * Odd-parity helper shared by the receiver.
// No ports (package).
package ps2_pkg;

  // Keys with a dedicated held level
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  // Keypad aliases (only mapped when PS2_KEYPAD_ALIAS_EN is defined)
  localparam logic [7:0] KP_1      = 8'h69;
  localparam logic [7:0] KP_2      = 8'h72;

  // Prefix bytes
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;

  // Receiver frame position
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // True when the eight data bits plus the parity bit hold an odd number of 1s
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame - PS/2 device-to-host frame receiver.
// Synchronises both raw lines, debounces the PS/2 clock, detects falling
// edges and assembles 11-bit frames (start, 8 data LSB first, odd parity,
// stop). A frame with a bad parity or stop bit, or one that stalls for
// TIMEOUT_CYCLES clk cycles between falling edges, is reported as an error.
//
// Parameters:
//   FILTER_LEN      consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYCLES  max clk cycles between falling edges inside a frame
// Ports:
//   clk      in   system clock
//   iReset   in   synchronous, active-high reset
//   iPS2Clk  in   raw PS/2 clock line (asynchronous)
//   iPS2Dat  in   raw PS/2 data line (asynchronous)
//   oByte    out  assembled data byte, valid while oGood is high
//   oGood    out  one-cycle strobe, in the stop-bit edge cycle, frame good
//   oErr     out  one-cycle strobe on parity, stop-bit or timeout error
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iPS2Clk,
  input  logic       iPS2Dat,
  output logic [7:0] oByte,
  output logic       oGood,
  output logic       oErr
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // Two-flop synchronisers; reset to the idle-high line level
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;

  always_ff @(posedge clk) begin
    if (iReset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], iPS2Clk};
      dat_sync <= {dat_sync[0], iPS2Dat};
    end
  end

  // Clock filter: the accepted level only moves after FILTER_LEN
  // consecutive samples that disagree with it.
  logic          filt_q;
  logic          filt_prev_q;
  logic [FW-1:0] flt_cnt_q;

  always_ff @(posedge clk) begin
    if (iReset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_sync[1] == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q    <= clk_sync[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end
    end
  end

  logic fall;
  logic dat_s;
  assign fall  = filt_prev_q & ~filt_q;
  assign dat_s = dat_sync[1];

  // Receiver FSM
  rx_state_t     state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          good, err;

  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    good    = 1'b0;
    err     = 1'b0;
    // Inter-edge timer runs only inside a frame and restarts on every edge
    to_d    = (fall || state_q == IDLE) ? '0 : to_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (fall && !dat_s) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {dat_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dat_s && odd_parity_ok(shift_q, par_q)) begin
            good = 1'b1;
          end else begin
            err = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !fall && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      err     = 1'b1;
      state_d = IDLE;
    end
  end

  assign oByte = shift_q;
  assign oGood = good;
  assign oErr  = err;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder - PS/2 keyboard front end for the main-menu controller.
// Receives scan-code set 2 frames, tracks the E0 (extended) and F0 (break)
// prefixes, and drives held levels for 1, 2, Space, Enter and Esc. Every
// good byte is also exposed with a one-cycle strobe.
//
// Optional feature (macro PS2_KEYPAD_ALIAS_EN): keypad 1 (0x69) and
// keypad 2 (0x72), non-extended, also drive oOnePressed / oTwoPressed. Each
// output is then the OR of two held bits.
//
// Parameters:
//   FILTER_LEN      PS/2 clock filter length in clk samples
//   TIMEOUT_CYCLES  max clk cycles between PS/2 clock falling edges
// Ports:
//   clk            in   system clock (50 MHz)
//   iReset         in   synchronous, active-high reset
//   iPS2Clk        in   raw PS/2 clock line
//   iPS2Dat        in   raw PS/2 data line
//   oOnePressed    out  key '1' held
//   oTwoPressed    out  key '2' held
//   oSpacePressed  out  Space held
//   oEnterPressed  out  Enter (main block) held
//   oEscPressed    out  Esc held
//   oScanCode      out  last good byte, prefixes included
//   oScanValid     out  one-cycle strobe when oScanCode updates
//   oFrameErr      out  one-cycle strobe on a bad or timed-out frame
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iPS2Clk,
  input  logic       iPS2Dat,
  output logic       oOnePressed,
  output logic       oTwoPressed,
  output logic       oSpacePressed,
  output logic       oEnterPressed,
  output logic       oEscPressed,
  output logic [7:0] oScanCode,
  output logic       oScanValid,
  output logic       oFrameErr
);

  logic [7:0] rx_byte;
  logic       rx_good;
  logic       rx_err;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .iReset  (iReset),
    .iPS2Clk (iPS2Clk),
    .iPS2Dat (iPS2Dat),
    .oByte   (rx_byte),
    .oGood   (rx_good),
    .oErr    (rx_err)
  );

  logic       ext_q, brk_q;
  logic       one_q, two_q, space_q, enter_q, esc_q;
  logic [7:0] scan_code_q;
  logic       scan_valid_q;
  logic       frame_err_q;
`ifdef PS2_KEYPAD_ALIAS_EN
  logic       kp1_q, kp2_q;
`endif

  // Strobes, scan code, prefix flags and key levels all register on the
  // receiver's stop-bit cycle, so they appear together one cycle later.
  always_ff @(posedge clk) begin
    if (iReset) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      one_q        <= 1'b0;
      two_q        <= 1'b0;
      space_q      <= 1'b0;
      enter_q      <= 1'b0;
      esc_q        <= 1'b0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_KEYPAD_ALIAS_EN
      kp1_q        <= 1'b0;
      kp2_q        <= 1'b0;
`endif
    end else begin
      scan_valid_q <= rx_good;
      frame_err_q  <= rx_err;
      if (rx_err) begin
        // Drop any pending prefix so a lost F0 cannot invert the next key
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_good) begin
        scan_code_q <= rx_byte;
        if (rx_byte == PFX_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == PFX_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          case (rx_byte)
            KEY_1:     one_q   <= ~brk_q;
            KEY_2:     two_q   <= ~brk_q;
            KEY_SPACE: space_q <= ~brk_q;
            KEY_ESC:   esc_q   <= ~brk_q;
            // E0 5A is keypad Enter, not the main Enter key
            KEY_ENTER: if (!ext_q) enter_q <= ~brk_q;
`ifdef PS2_KEYPAD_ALIAS_EN
            // E0 69 / E0 72 are End / Down
            KP_1:      if (!ext_q) kp1_q <= ~brk_q;
            KP_2:      if (!ext_q) kp2_q <= ~brk_q;
`endif
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PS2_KEYPAD_ALIAS_EN
  assign oOnePressed = one_q | kp1_q;
  assign oTwoPressed = two_q | kp2_q;
`else
  assign oOnePressed = one_q;
  assign oTwoPressed = two_q;
`endif
  assign oSpacePressed = space_q;
  assign oEnterPressed = enter_q;
  assign oEscPressed   = esc_q;
  assign oScanCode     = scan_code_q;
  assign oScanValid    = scan_valid_q;
  assign oFrameErr     = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the main-menu controller.
- Receives raw PS/2 keyboard frames (scan code set 2), tracks make/break prefixes, and drives per-key "held" levels for 1, 2, Space, Enter and Esc.
- The menu and game FSMs consume these levels directly.
- Also exposes each received byte with a one-cycle valid strobe, for the game blocks.

Parameters:
- FILTER_LEN, 8, number of consecutive identical clk samples required before the synchronised PS/2 clock level is accepted.
- TIMEOUT_CYCLES, 50000, maximum clk cycles between PS/2 clock falling edges inside a frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- iReset  in  1  synchronous, active-high reset.
- iPS2Clk  in  1  raw PS/2 clock line, asynchronous.
- iPS2Dat  in  1  raw PS/2 data line, asynchronous.
- oOnePressed  out  1  high while key '1' (0x16) is held.
- oTwoPressed  out  1  high while key '2' (0x1E) is held.
- oSpacePressed  out  1  high while Space (0x29) is held.
- oEnterPressed  out  1  high while Enter (0x5A, non-extended) is held.
- oEscPressed  out  1  high while Esc (0x76) is held.
- oScanCode  out  8  last good byte received, prefixes included.
- oScanValid  out  1  one-cycle strobe when oScanCode updates.
- oFrameErr  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

Behaviour:
- Reset: iReset is synchronous, active-high; clock is clk. While iReset is high:
  - all outputs are 0 and oScanCode = 0x00;
  - prefix flags are cleared, receiver returns to IDLE, filter and timeout counters are cleared.
  - This applies even mid-frame; any partial frame is dropped without a strobe.
- Input conditioning:
  - Both lines pass through a 2-flop synchroniser.
  - Clock filter: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - Falling edge = filtered level goes 1 to 0.
  - Data is sampled from the synchronised data line in the cycle the falling edge is detected.
- Receiver FSM (advances only on a falling edge, except for timeout):
  - IDLE: sampled data 0 (start bit) -> DATA with bit count 0. Sampled data 1 -> stay in IDLE.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: sampled data 1 and odd parity correct (data bits plus parity bit contain an odd number of 1s) -> byte good. Otherwise pulse oFrameErr. Either case -> IDLE.
  - Timeout: in any state other than IDLE, if TIMEOUT_CYCLES elapse with no falling edge, pulse oFrameErr and go to IDLE.
- Decoder (acts on good bytes only):
  - On a good byte, oScanCode is set and oScanValid pulses in the cycle after the stop-bit edge.
  - 0xE0 sets the ext flag; 0xF0 sets the brk flag. Key levels do not change.
  - Any other byte with brk = 0 is a make: the matching key level goes to 1.
  - Any other byte with brk = 1 is a break: the matching key level goes to 0.
  - Key levels update in the same cycle as oScanValid. ext and brk both clear after any non-prefix byte.
  - When ext = 1, only Enter ignores the byte (E0 5A is keypad Enter). The other four keys have no extended aliases in this map, so ext is otherwise ignored.
  - Typematic repeat makes hold the level at 1, with no toggling.
  - Unmapped codes update oScanCode and pulse oScanValid only.
- Errors:
  - A bad frame does not update oScanCode or any key level.
  - A bad frame clears ext and brk, so a lost F0 cannot invert the next byte.
- Key independence: all five key levels are independent; several may be high at once.

Optional Feature:
- Macro: PS2_KEYPAD_ALIAS_EN.
- Defined: with ext = 0, keypad 1 (0x69) also drives oOnePressed and keypad 2 (0x72) also drives oTwoPressed, with make/break as above.
  - Each output is the OR of two internal held bits, so it stays high until both its keys are released.
  - With ext = 1, 0x69 and 0x72 are End and Down and are ignored.
- Undefined: 0x69 and 0x72 are treated as unmapped.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants (KEY_1, KEY_2, KEY_SPACE, KEY_ENTER, KEY_ESC, KP_1, KP_2, PFX_EXT, PFX_BRK);
  - the receiver state encoding (IDLE, DATA, PARITY, STOP).
- One sub-module is natural: ps2_rx_frame. It contains the synchroniser, filter, receiver FSM, parity check and timeout, and produces a byte with a good/error strobe.
- The top level keeps the prefix flags and the key map.

Test Plan:
- Frame 0x16 (odd parity 0, stop 1) -> oScanCode = 0x16, oScanValid high 1 cycle, oOnePressed = 1. Then F0, 16 -> oOnePressed = 0, with two strobes seen.
- Make 0x1E, then make 0x29, then F0 1E -> oTwoPressed goes 1 then 0; oSpacePressed stays 1 throughout.
- Frame 0x16 with parity bit flipped -> oFrameErr pulses, no oScanValid, oOnePressed stays 0. Also send F0, then a bad frame, then 16 -> oOnePressed = 1 (brk was cleared by the error).
- Send E0 5A -> oEnterPressed stays 0. Then send 5A -> oEnterPressed = 1.
- Stop after 4 data bits with the line idle for 50000 cycles -> oFrameErr pulses at cycle 50000. A following clean 0x76 -> oEscPressed = 1.
- Assert iReset for 1 cycle mid-frame while oOnePressed = 1 -> all outputs 0 next cycle. The remainder of the frame is ignored, with no strobe.
